vga_sync_generator: RTL and testbench

- Produces VGA horizontal/vertical timing (hsync, vsync, video_on, pixel coordinates) for the display pipeline.
- Consumer side of the pixel-rate divider: counts one pixel per pixel_en pulse from the divider, all in the system clock domain.
- Default timing is 640x480@60 Hz (25 MHz pixel rate from a 100 MHz clock divided by 4).

---
 rtl/vga_sync_generator_if.sv | 21 ++
 rtl/vga_sync_generator.sv | 71 +++++++
 tb/tb_vga_sync_generator.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_generator_if.sv
// vga_sync_generator_if: pixel-enable input and timing outputs of the VGA sync generator.
interface vga_sync_generator_if #(
   parameter int CNT_W = 10
);
   logic             pixel_en;
   logic [CNT_W-1:0] pixel_x;
   logic [CNT_W-1:0] pixel_y;
   logic             hsync;
   logic             vsync;
   logic             video_on;
   logic             line_start;
   logic             frame_start;
   modport master (
      output pixel_en,
      input  pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
   );
   modport slave (
      input  pixel_en,
      output pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
   );
endinterface

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA h/v counters with registered sync, video_on and line/frame start pulses.
module vga_sync_generator #(
   parameter int H_ACTIVE        = 640,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int V_ACTIVE        = 480,
   parameter int V_FP            = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int CNT_W           = 10
) (
   input logic               clock_in,
   input logic               reset_n,
   vga_sync_generator_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] X_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] Y_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic SYNC_ON = (SYNC_ACTIVE_LOW == 0);
   logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
   logic hs_q, hs_d, vs_q, vs_d, vo_q, vo_d, ls_q, ls_d, fs_q, fs_d;
   logic x_wrap, y_wrap;
   // Level outputs decode the next-state counters so they line up with pixel_x/pixel_y.
   always_comb begin
      x_wrap = x_q == X_LAST;
      y_wrap = y_q == Y_LAST;
      x_d    = bus.pixel_en ? (x_wrap ? '0 : x_q + 1'b1) : x_q;
      y_d    = (bus.pixel_en && x_wrap) ? (y_wrap ? '0 : y_q + 1'b1) : y_q;
      hs_d   = (x_d >= HS_BEG && x_d < HS_END) ? SYNC_ON : ~SYNC_ON;
      vs_d   = (y_d >= VS_BEG && y_d < VS_END) ? SYNC_ON : ~SYNC_ON;
      vo_d   = x_d < X_ACT && y_d < Y_ACT;
      ls_d   = bus.pixel_en && x_wrap;
      fs_d   = ls_d && y_wrap;
   end
   // Reset lands on the last pixel of a frame so the first enable wraps to (0,0).
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         x_q  <= X_LAST;
         y_q  <= Y_LAST;
         hs_q <= ~SYNC_ON;
         vs_q <= ~SYNC_ON;
         vo_q <= 1'b0;
         ls_q <= 1'b0;
         fs_q <= 1'b0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         vo_q <= vo_d;
         ls_q <= ls_d;
         fs_q <= fs_d;
      end
   end
   assign bus.pixel_x     = x_q;
   assign bus.pixel_y     = y_q;
   assign bus.hsync       = hs_q;
   assign bus.vsync       = vs_q;
   assign bus.video_on    = vo_q;
   assign bus.line_start  = ls_q;
   assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: checks a 640x480 instance against a pixel-index model, plus a small active-high instance.
module tb_vga_sync_generator;
   localparam int AH = 800, AV = 525, AT = AH * AV;
   localparam int BH = 15, BV = 10, BT = BH * BV;
   logic clock_in = 1'b0;
   logic reset_n  = 1'b1;
   logic rb_n     = 1'b1;
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   ma_p = AT - 1, mb_p = BT - 1;
   bit   ma_ls, ma_fs, mb_ls, mb_fs;
   always #5 clock_in = ~clock_in;
   vga_sync_generator_if #(.CNT_W(10)) ifa ();
   vga_sync_generator_if #(.CNT_W(4))  ifb ();
   vga_sync_generator dut_a (.clock_in(clock_in), .reset_n(reset_n), .bus(ifa));
   vga_sync_generator #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_ACTIVE_LOW(0), .CNT_W(4)
   ) dut_b (.clock_in(clock_in), .reset_n(rb_n), .bus(ifb));
   assign ifb.pixel_en = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a linear pixel index within the frame; coordinates and decode follow from it.
   always @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         ma_p <= AT - 1; ma_ls <= 1'b0; ma_fs <= 1'b0;
      end else begin
         ma_p  <= ifa.pixel_en ? (ma_p + 1) % AT : ma_p;
         ma_ls <= ifa.pixel_en && ((ma_p + 1) % AH == 0);
         ma_fs <= ifa.pixel_en && ((ma_p + 1) % AT == 0);
      end
   end
   always @(posedge clock_in or negedge rb_n) begin
      if (!rb_n) begin
         mb_p <= BT - 1; mb_ls <= 1'b0; mb_fs <= 1'b0;
      end else begin
         mb_p  <= (mb_p + 1) % BT;
         mb_ls <= ((mb_p + 1) % BH == 0);
         mb_fs <= ((mb_p + 1) % BT == 0);
      end
   end

   task automatic check_dut(input string t, input int x, input int y, input logic hs, input logic vs,
                            input logic vo, input logic ls, input logic fs, input int p, input int ht,
                            input int ha, input int hf, input int hw, input int va, input int vf,
                            input int vw, input bit low, input bit mls, input bit mfs);
      int ex, ey;
      bit on;
      ex = p % ht;
      ey = p / ht;
      on = !low;
      chk({t, "_x"}, x, ex);
      chk({t, "_y"}, y, ey);
      chk({t, "_hsync"}, 32'(hs), 32'((ex >= ha + hf && ex < ha + hf + hw) ? on : !on));
      chk({t, "_vsync"}, 32'(vs), 32'((ey >= va + vf && ey < va + vf + vw) ? on : !on));
      chk({t, "_video_on"}, 32'(vo), 32'(ex < ha && ey < va));
      chk({t, "_line_start"}, 32'(ls), 32'(mls));
      chk({t, "_frame_start"}, 32'(fs), 32'(mfs));
   endtask

   always @(negedge clock_in) begin
      check_dut("a", int'(ifa.pixel_x), int'(ifa.pixel_y), ifa.hsync, ifa.vsync, ifa.video_on,
                ifa.line_start, ifa.frame_start, ma_p, AH, 640, 16, 96, 480, 10, 2, 1'b1, ma_ls, ma_fs);
      check_dut("b", int'(ifb.pixel_x), int'(ifb.pixel_y), ifb.hsync, ifb.vsync, ifb.video_on,
                ifb.line_start, ifb.frame_start, mb_p, BH, 8, 2, 3, 6, 1, 2, 1'b0, mb_ls, mb_fs);
   end

   task automatic tick(input int gap);
      ifa.pixel_en = 1'b1;
      @(posedge clock_in); #1;
      ifa.pixel_en = 1'b0;
      repeat (gap) begin @(posedge clock_in); #1; end
   endtask

   task automatic lit_a(input string t, input int x, input int y, input logic hs, input logic vs,
                        input logic vo, input logic ls, input logic fs);
      chk({t, "_x"}, 32'(ifa.pixel_x), x);
      chk({t, "_y"}, 32'(ifa.pixel_y), y);
      chk({t, "_hsync"}, 32'(ifa.hsync), 32'(hs));
      chk({t, "_vsync"}, 32'(ifa.vsync), 32'(vs));
      chk({t, "_video_on"}, 32'(ifa.video_on), 32'(vo));
      chk({t, "_line_start"}, 32'(ifa.line_start), 32'(ls));
      chk({t, "_frame_start"}, 32'(ifa.frame_start), 32'(fs));
   endtask

   task automatic lit_b(input string t, input int x, input int y, input logic hs, input logic vs,
                        input logic vo, input logic ls, input logic fs);
      chk({t, "_x"}, 32'(ifb.pixel_x), x);
      chk({t, "_y"}, 32'(ifb.pixel_y), y);
      chk({t, "_hsync"}, 32'(ifb.hsync), 32'(hs));
      chk({t, "_vsync"}, 32'(ifb.vsync), 32'(vs));
      chk({t, "_video_on"}, 32'(ifb.video_on), 32'(vo));
      chk({t, "_line_start"}, 32'(ifb.line_start), 32'(ls));
      chk({t, "_frame_start"}, 32'(ifb.frame_start), 32'(fs));
   endtask

   initial begin
      int hs_lo, vo_fall, hs_fall, hs_rise, cnt, vs_n, vo_n, hb_n, k;
      logic pv, ph;
      ifa.pixel_en = 1'b0;
      #1 reset_n = 1'b0; rb_n = 1'b0;
      repeat (2) @(posedge clock_in);
      #1 lit_a("rst", 799, 524, 1, 1, 0, 0, 0);
      reset_n = 1'b1;
      @(posedge clock_in); #1;
      lit_a("idle", 799, 524, 1, 1, 0, 0, 0);
      tick(0);
      lit_a("first", 0, 0, 1, 1, 1, 1, 1);
      @(posedge clock_in); #1;
      lit_a("first_next", 0, 0, 1, 1, 1, 0, 0);
      hs_lo = 0; vo_fall = -1; hs_fall = -1; hs_rise = -1;
      for (int i = 0; i < 799; i++) begin
         pv = ifa.video_on; ph = ifa.hsync;
         hs_lo += (ifa.hsync == 1'b0) ? 1 : 0;
         tick(3);
         if (pv && !ifa.video_on) vo_fall = int'(ifa.pixel_x);
         if (ph && !ifa.hsync) hs_fall = int'(ifa.pixel_x);
         if (!ph && ifa.hsync) hs_rise = int'(ifa.pixel_x);
      end
      hs_lo += (ifa.hsync == 1'b0) ? 1 : 0;
      chk("line_end_x", 32'(ifa.pixel_x), 799);
      chk("hsync_low_ticks", hs_lo, 96);
      chk("video_off_x", vo_fall, 640);
      chk("hsync_fall_x", hs_fall, 656);
      chk("hsync_rise_x", hs_rise, 752);
      tick(0);
      lit_a("line2", 0, 1, 1, 1, 1, 1, 0);
      @(posedge clock_in); #1;
      chk("line2_ls_drop", 32'(ifa.line_start), 0);
      ifa.pixel_en = 1'b1;
      repeat (300) @(posedge clock_in);
      #1 ifa.pixel_en = 1'b0;
      lit_a("at300", 300, 1, 1, 1, 1, 0, 0);
      repeat (50) begin @(posedge clock_in); #1; end
      lit_a("hold50", 300, 1, 1, 1, 1, 0, 0);
      tick(0);
      lit_a("after_hold", 301, 1, 1, 1, 1, 0, 0);
      ifa.pixel_en = 1'b1;
      repeat (399) @(posedge clock_in);
      #1 ifa.pixel_en = 1'b0;
      lit_a("at700", 700, 1, 0, 1, 0, 0, 0);
      #2 reset_n = 1'b0;
      #1 lit_a("async_rst", 799, 524, 1, 1, 0, 0, 0);
      @(posedge clock_in); #1 reset_n = 1'b1;
      tick(0);
      lit_a("post_rst", 0, 0, 1, 1, 1, 1, 1);

      @(posedge clock_in); #1 rb_n = 1'b1;
      @(posedge clock_in); #1;
      lit_b("b_first", 0, 0, 0, 0, 1, 1, 1);
      cnt = 0; vs_n = 0; vo_n = 0; hb_n = 0;
      do begin
         vs_n += int'(ifb.vsync); vo_n += int'(ifb.video_on); hb_n += int'(ifb.hsync);
         @(posedge clock_in); #1;
         cnt++;
      end while (!ifb.frame_start && cnt < 400);
      chk("b_frame_period", cnt, BT);
      chk("b_vsync_ticks", vs_n, 2 * BH);
      chk("b_video_ticks", vo_n, 48);
      chk("b_hsync_ticks", hb_n, 3 * BV);
      k = 0;
      while (!(ifb.pixel_x == 4'd11 && ifb.pixel_y == 4'd7) && k < 400) begin
         @(posedge clock_in); #1;
         k++;
      end
      chk("b_seek_x11_y7", 32'(k), 116);
      lit_b("b_sync_on", 11, 7, 1, 1, 0, 0, 0);
      #2 rb_n = 1'b0;
      #1 lit_b("b_async_rst", 14, 9, 0, 0, 0, 0, 0);
      @(posedge clock_in); #1 rb_n = 1'b1;
      @(posedge clock_in); #1;
      lit_b("b_post_rst", 0, 0, 0, 0, 1, 1, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
